wb_select_pipe: RTL and testbench
=================================

Name: wb_select_pipe

Overview:
- Parametrised, pipelined successor to the writeback-path selectors in the single-cycle core: an N-way data select and an M-way destination-register select, registered behind a valid/ready handshake.
- Sits between the EX/MEM result sources (ALU, memory, PC+8, immediate, ...) and the register-file write port of the pipelined core.
- A 2-entry skid buffer gives full throughput with registered in_ready; flush squashes in-flight entries.

Parameters:
- WIDTH, 32, data width of every source and of wb_data.
- NUM_SRC, 4, number of data sources (>=2).
- NUM_DST, 3, number of destination-register candidates (>=2), e.g. rt, rd, 31.
- AW, 5, register address width.
- SEL_W, $clog2(NUM_SRC), width of data_sel.
- DSEL_W, $clog2(NUM_DST), width of dst_sel.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  block can accept; registered, depends only on occupancy.
- src_data  in  NUM_SRC*WIDTH  packed sources; source k at bits [k*WIDTH +: WIDTH].
- data_sel  in  SEL_W  selects the source.
- dst_cand  in  NUM_DST*AW  packed destination candidates; candidate j at bits [j*AW +: AW].
- dst_sel  in  DSEL_W  selects the destination.
- reg_we_in  in  1  entry intends a register write.
- out_valid  out  1  wb_* fields valid.
- out_ready  in  1  downstream accepts.
- wb_data  out  WIDTH  selected data.
- wb_addr  out  AW  selected destination.
- wb_we  out  1  write enable; forced 0 when wb_addr==0.
- sel_err  out  1  sticky: an out-of-range select was accepted.

Behaviour:
- Reset (rst_n=0, async): both buffer entries empty; out_valid=0, in_ready=1, wb_data=0, wb_addr=0, wb_we=0, sel_err=0. Reset mid-transfer discards all entries with no output.
- Accept: in_valid && in_ready at an edge. Selection is done at accept; only the selected result is stored (WIDTH+AW+1 bits per entry).
- Latency: accepted entry appears on wb_* at the next cycle (1 cycle) when the buffer was empty.
- Storage: main register (drives outputs) plus skid register.
  - Occupancy states: EMPTY, ONE, TWO.
  - EMPTY -accept-> ONE.
  - ONE: accept and no pop -> TWO; pop and no accept -> EMPTY; accept and pop -> ONE, new entry in main.
  - TWO: pop -> ONE, skid moves to main. Accept is impossible in TWO.
- Pop: out_valid && out_ready. in_ready = (state != TWO), registered.
- Order: strict FIFO; no entry is dropped or duplicated.
- Hold: while out_valid && !out_ready, wb_* are stable.
- Out-of-range select:
  - data_sel >= NUM_SRC stores wb_data=0.
  - dst_sel >= NUM_DST stores wb_addr=0 and we=0.
  - Either case sets sel_err at the accept edge. sel_err clears only on reset.
- Zero register: stored we = reg_we_in && (addr != 0).
- Flush: next state EMPTY, out_valid=0, in_ready=1. Any accept in the same cycle is squashed. wb_data/wb_addr keep their values (don't-care). sel_err is unaffected.
- Simultaneous flush and pop: flush wins. The downstream pop counts as not having occurred for the entries dropped.
- No combinational path from in_* or out_ready to out_valid, in_ready, or wb_*.

Decomposition:
- Shared package wb_pkg:
  - DEFAULT_WIDTH and DEFAULT_AW constants.
  - Source-index localparams: SRC_ALU=0, SRC_MEM=1, SRC_PC8=2, SRC_IMM=3.
  - Destination-index localparams: DST_RT=0, DST_RD=1, DST_RA=2.
  - REG_ZERO = 0.
- One sub-module: onehot-free combinational selector wb_sel_mux(WIDTH, NUM), with an index-in/valid-out range check. It is instantiated twice, once for data and once for address.

Test Plan:
- Reset then single write:
  - Stimulus: src_data={ALU=0x11, MEM=0x22, PC8=0x33, IMM=0x44}, data_sel=1, dst_cand={rt=5, rd=9, ra=31}, dst_sel=2, reg_we_in=1, out_ready=1.
  - Required: one cycle later out_valid=1, wb_data=0x22, wb_addr=31, wb_we=1.
- Back-pressure and skid:
  - Stimulus: out_ready=0, three consecutive in_valid entries with data 0xA, 0xB, 0xC.
  - Required: first two accepted; in_ready=0 after the second; 0xC held. Raise out_ready: outputs 0xA, 0xB, 0xC in order, one per cycle, no gaps.
- Full throughput: in_valid=out_ready=1 continuously for 16 entries (data = i) -> wb_data = 0..15 on consecutive cycles; in_ready stays 1.
- Zero register and range check:
  - dst_sel=0 with rt=0 and reg_we_in=1 -> wb_we=0.
  - data_sel=5 with NUM_SRC=4 (SEL_W forced 3 via a parameter override) -> wb_data=0, sel_err=1, and sel_err remains 1 after a flush.
- Flush with buffer in TWO, plus a simultaneous accept -> next cycle out_valid=0, in_ready=1; the squashed entry never appears.
- Async reset asserted mid-stream between clock edges -> outputs go to reset values immediately, without waiting for a clk edge. After release, the first new entry appears with 1-cycle latency.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback select pipeline.
package wb_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_AW    = 5;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_PC8 = 2;
    localparam int SRC_IMM = 3;

    localparam int DST_RT = 0;
    localparam int DST_RD = 1;
    localparam int DST_RA = 2;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_e;

endpackage

// File: rtl/wb_sel_mux.sv
// Indexed selector over a packed vector of NUM fields; valid_o flags an in-range index.
module wb_sel_mux #(
    parameter int WIDTH = 32,
    parameter int NUM   = 4,
    parameter int IDX_W = $clog2(NUM)
) (
    input  logic [NUM*WIDTH-1:0] in_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic [WIDTH-1:0]     out_o,
    output logic                 valid_o
);

    // An out-of-range index matches no field, so the output stays zero.
    always_comb begin
        out_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 0; k < NUM; k++) begin
            if (idx_i == IDX_W'(k)) begin
                out_o   = in_i[k*WIDTH +: WIDTH];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_select_pipe.sv
// Registered writeback data/destination select behind a valid/ready handshake,
// with a main + skid register pair so in_ready can be registered at full throughput.
module wb_select_pipe
    import wb_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NUM_SRC = 4,
    parameter int NUM_DST = 3,
    parameter int AW      = DEFAULT_AW,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int DSEL_W  = $clog2(NUM_DST)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]       data_sel,
    input  logic [NUM_DST*AW-1:0]  dst_cand,
    input  logic [DSEL_W-1:0]      dst_sel,
    input  logic                   reg_we_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       wb_data,
    output logic [AW-1:0]          wb_addr,
    output logic                   wb_we,
    output logic                   sel_err
);

    occ_e             state_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             sel_err_q;
    logic [WIDTH-1:0] main_data_q, skid_data_q;
    logic [AW-1:0]    main_addr_q, skid_addr_q;
    logic             main_we_q, skid_we_q;

    logic [WIDTH-1:0] mux_data;
    logic [AW-1:0]    mux_addr;
    logic             data_ok, addr_ok;

    logic [WIDTH-1:0] new_data_d;
    logic [AW-1:0]    new_addr_d;
    logic             new_we_d;
    logic             sel_ok_d;
    logic             accept, pop;

    wb_sel_mux #(.WIDTH(WIDTH), .NUM(NUM_SRC), .IDX_W(SEL_W)) u_data_mux (
        .in_i    (src_data),
        .idx_i   (data_sel),
        .out_o   (mux_data),
        .valid_o (data_ok)
    );

    wb_sel_mux #(.WIDTH(AW), .NUM(NUM_DST), .IDX_W(DSEL_W)) u_addr_mux (
        .in_i    (dst_cand),
        .idx_i   (dst_sel),
        .out_o   (mux_addr),
        .valid_o (addr_ok)
    );

    always_comb begin
        new_data_d = data_ok ? mux_data : '0;
        new_addr_d = addr_ok ? mux_addr : '0;
        new_we_d   = reg_we_in && addr_ok && (new_addr_d != AW'(REG_ZERO));
        sel_ok_d   = data_ok && addr_ok;
        accept     = in_valid && in_ready_q;
        pop        = out_valid_q && out_ready;
    end

    // Flush takes priority over both accept and pop; sel_err is left untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            sel_err_q   <= 1'b0;
            main_data_q <= '0;
            main_addr_q <= '0;
            main_we_q   <= 1'b0;
            skid_data_q <= '0;
            skid_addr_q <= '0;
            skid_we_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= OCC_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (accept && !sel_ok_d) begin
                sel_err_q <= 1'b1;
            end
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_data_q <= new_data_d;
                        main_addr_q <= new_addr_d;
                        main_we_q   <= new_we_d;
                        state_q     <= OCC_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && !pop) begin
                        skid_data_q <= new_data_d;
                        skid_addr_q <= new_addr_d;
                        skid_we_q   <= new_we_d;
                        state_q     <= OCC_TWO;
                        in_ready_q  <= 1'b0;
                    end else if (pop && !accept) begin
                        state_q     <= OCC_EMPTY;
                        out_valid_q <= 1'b0;
                    end else if (accept && pop) begin
                        main_data_q <= new_data_d;
                        main_addr_q <= new_addr_d;
                        main_we_q   <= new_we_d;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        main_data_q <= skid_data_q;
                        main_addr_q <= skid_addr_q;
                        main_we_q   <= skid_we_q;
                        state_q     <= OCC_ONE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= OCC_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign wb_data   = main_data_q;
    assign wb_addr   = main_addr_q;
    assign wb_we     = main_we_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed, table-driven bench for wb_select_pipe with hand-computed expectations.
module tb_wb_select_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] src_data;
    logic [2:0]   data_sel;
    logic [14:0]  dst_cand;
    logic [1:0]   dst_sel;
    logic         reg_we_in;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  wb_data;
    logic [4:0]   wb_addr;
    logic         wb_we;
    logic         sel_err;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [14:0] CAND_STD  = {5'd31, 5'd9, 5'd5};
    localparam logic [14:0] CAND_RT0  = {5'd31, 5'd9, 5'd0};

    always #5 clk = ~clk;

    wb_select_pipe #(.WIDTH(32), .NUM_SRC(4), .NUM_DST(3), .AW(5), .SEL_W(3), .DSEL_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_data  (src_data),
        .data_sel  (data_sel),
        .dst_cand  (dst_cand),
        .dst_sel   (dst_sel),
        .reg_we_in (reg_we_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_data   (wb_data),
        .wb_addr   (wb_addr),
        .wb_we     (wb_we),
        .sel_err   (sel_err)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  dsel_data;
        logic [1:0]  dsel_dst;
        logic [14:0] cand;
        logic        we;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [4:0]  exp_addr;
        logic        exp_we;
        logic        exp_in_ready;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [31:0] v);
        src_data = {32'h44, 32'h33, 32'h22, v};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //               v  dsel  dst  cand      we rdy  ev edata   eaddr we  inrdy
        vecs[0] = '{1'b1, 3'd1, 2'd2, CAND_STD, 1'b1, 1'b1, 1'b1, 32'h22, 5'd31, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 3'd0, 2'd1, CAND_STD, 1'b1, 1'b1, 1'b1, 32'h11, 5'd9,  1'b1, 1'b1};
        vecs[2] = '{1'b1, 3'd3, 2'd0, CAND_STD, 1'b0, 1'b1, 1'b1, 32'h44, 5'd5,  1'b0, 1'b1};
        vecs[3] = '{1'b1, 3'd2, 2'd0, CAND_RT0, 1'b1, 1'b1, 1'b1, 32'h33, 5'd0,  1'b0, 1'b1};
        vecs[4] = '{1'b0, 3'd0, 2'd0, CAND_STD, 1'b0, 1'b1, 1'b0, 32'h33, 5'd0,  1'b0, 1'b1};
        vecs[5] = '{1'b1, 3'd3, 2'd1, CAND_STD, 1'b1, 1'b0, 1'b1, 32'h44, 5'd9,  1'b1, 1'b1};
        vecs[6] = '{1'b0, 3'd0, 2'd0, CAND_STD, 1'b0, 1'b0, 1'b1, 32'h44, 5'd9,  1'b1, 1'b1};
        vecs[7] = '{1'b0, 3'd0, 2'd0, CAND_STD, 1'b0, 1'b0, 1'b1, 32'h44, 5'd9,  1'b1, 1'b1};
        vecs[8] = '{1'b0, 3'd0, 2'd0, CAND_STD, 1'b0, 1'b1, 1'b0, 32'h44, 5'd9,  1'b1, 1'b1};

        flush = 1'b0; in_valid = 1'b0; data_sel = '0; dst_sel = '0;
        dst_cand = CAND_STD; reg_we_in = 1'b0; out_ready = 1'b1;
        set_alu(32'h11);
        do_reset();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset wb_data",   wb_data,        32'd0);
        check("reset wb_addr",   32'(wb_addr),   32'd0);
        check("reset wb_we",     32'(wb_we),     32'd0);
        check("reset sel_err",   32'(sel_err),   32'd0);

        for (int i = 0; i < 9; i++) begin
            in_valid = vecs[i].valid; data_sel = vecs[i].dsel_data; dst_sel = vecs[i].dsel_dst;
            dst_cand = vecs[i].cand; reg_we_in = vecs[i].we; out_ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d wb_data", i),   wb_data,        vecs[i].exp_data);
            check($sformatf("vec%0d wb_addr", i),   32'(wb_addr),   32'(vecs[i].exp_addr));
            check($sformatf("vec%0d wb_we", i),     32'(wb_we),     32'(vecs[i].exp_we));
            check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_in_ready));
        end
        in_valid = 1'b0; dst_cand = CAND_STD; dst_sel = 2'd1; data_sel = 3'd0; reg_we_in = 1'b1;

        // Back-pressure into the skid register, then drain in order.
        out_ready = 1'b0; in_valid = 1'b1;
        set_alu(32'hA); tick();
        check("bp A in_ready", 32'(in_ready), 32'd1);
        check("bp A data", wb_data, 32'hA);
        set_alu(32'hB); tick();
        check("bp B in_ready", 32'(in_ready), 32'd0);
        check("bp B data held", wb_data, 32'hA);
        set_alu(32'hC); tick();
        check("bp C not accepted in_ready", 32'(in_ready), 32'd0);
        check("bp hold A", wb_data, 32'hA);
        check("bp hold valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; tick();
        check("bp drain B", wb_data, 32'hB);
        check("bp drain B valid", 32'(out_valid), 32'd1);
        tick();
        check("bp drain C", wb_data, 32'hC);
        check("bp drain C valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; tick();
        check("bp empty", 32'(out_valid), 32'd0);

        // Full throughput.
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_alu(32'(i)); tick();
            check($sformatf("thr%0d data", i), wb_data, 32'(i));
            check($sformatf("thr%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("thr%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0; tick();
        check("thr drained", 32'(out_valid), 32'd0);

        // Flush in TWO with out_ready high and an input presented.
        out_ready = 1'b0; in_valid = 1'b1;
        set_alu(32'h50); tick();
        set_alu(32'h51); tick();
        check("fl two in_ready", 32'(in_ready), 32'd0);
        set_alu(32'h52); flush = 1'b1; out_ready = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl two out_valid", 32'(out_valid), 32'd0);
        check("fl two in_ready after", 32'(in_ready), 32'd1);
        tick();
        check("fl two stays empty", 32'(out_valid), 32'd0);

        // Flush in ONE with a real accept in the same cycle.
        in_valid = 1'b1; out_ready = 1'b0;
        set_alu(32'h60); tick();
        set_alu(32'h61); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl one out_valid", 32'(out_valid), 32'd0);
        tick();
        check("fl one squashed", 32'(out_valid), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; set_alu(32'h62); tick();
        in_valid = 1'b0;
        check("fl after data", wb_data, 32'h62);
        check("fl after valid", 32'(out_valid), 32'd1);
        check("sel_err still clear", 32'(sel_err), 32'd0);
        tick();

        // Out-of-range data select; sel_err survives flush, clears on reset.
        in_valid = 1'b1; data_sel = 3'd5; dst_sel = 2'd1; reg_we_in = 1'b1; tick();
        in_valid = 1'b0; data_sel = 3'd0;
        check("rng data zero", wb_data, 32'd0);
        check("rng data addr", 32'(wb_addr), 32'd9);
        check("rng data sel_err", 32'(sel_err), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("rng sel_err after flush", 32'(sel_err), 32'd1);
        do_reset();
        check("rng sel_err after reset", 32'(sel_err), 32'd0);
        in_valid = 1'b1; data_sel = 3'd1; dst_sel = 2'd3; tick();
        in_valid = 1'b0;
        check("rng dst data", wb_data, 32'h22);
        check("rng dst addr", 32'(wb_addr), 32'd0);
        check("rng dst we", 32'(wb_we), 32'd0);
        check("rng dst sel_err", 32'(sel_err), 32'd1);
        tick();

        // Async reset between edges.
        dst_sel = 2'd1; data_sel = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
        set_alu(32'h70); tick();
        set_alu(32'h71); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst in_ready", 32'(in_ready), 32'd1);
        check("arst wb_data", wb_data, 32'd0);
        check("arst sel_err", 32'(sel_err), 32'd0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1; set_alu(32'h77);
        tick();
        in_valid = 1'b0;
        check("arst first data", wb_data, 32'h77);
        check("arst first valid", 32'(out_valid), 32'd1);
        check("arst first addr", 32'(wb_addr), 32'd9);
        tick();
        check("arst drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
